// File: rtl/am_envelope_detector.sv
// AM envelope detector: d_out = floor(sqrt(I^2 + Q^2)) per accepted I/Q sample.
// Optional DC blocker on the magnitude when DC_BLOCK_EN is defined.
module am_envelope_detector #(
    parameter int DW = 8,
    parameter int K  = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] I_in,
    input  logic [DW-1:0] Q_in,
    output logic [DW-1:0] d_out,
    output logic          d_valid,
    output logic          overrun
);

    // Handshake: a sample transfers on a posedge where in_valid && in_ready.
    // in_ready is high only in IDLE; in_valid while not ready drops the sample
    // and sets the sticky overrun flag. d_valid is a one-cycle pulse.

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_I = 3'd1,
        MUL_Q = 3'd2,
        ROOT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [DW-1:0]   i_reg;
    logic signed [DW-1:0]   q_reg;
    logic [2*DW-1:0]        isq;
    logic [2*DW-1:0]        rad;
    logic [DW-1:0]          rem;
    logic [DW-1:0]          root;
    logic [CW-1:0]          count;

    logic signed [DW-1:0]   mul_op;
    logic signed [2*DW-1:0] prod;
    logic [DW+1:0]          rem_shift;
    logic [DW+1:0]          trial;
    logic                   take;
    logic [DW-1:0]          result;

    // One shared squarer: I in MUL_I, Q in MUL_Q.
    assign mul_op = (state == MUL_Q) ? q_reg : i_reg;
    assign prod   = mul_op * mul_op;

    // Restoring sqrt step: bring down two radicand bits, try root*4+1.
    assign rem_shift = {rem, rad[2*DW-1 -: 2]};
    assign trial     = {root, 2'b01};
    assign take      = (rem_shift >= trial);

`ifdef DC_BLOCK_EN
    logic [DW+K-1:0]     avg;
    logic [DW-1:0]       avg_int;
    logic signed [DW+1:0] diff;

    assign avg_int = avg[DW+K-1:K];
    assign diff    = $signed({2'b00, root}) - $signed({2'b00, avg_int});

    // Saturate the DW+2 bit difference into a DW-bit signed result.
    always_comb begin
        result = diff[DW-1:0];
        if (!((diff[DW+1:DW-1] == 3'b000) || (diff[DW+1:DW-1] == 3'b111))) begin
            result = diff[DW+1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end
`else
    assign result = root;
`endif

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        case (state)
            IDLE:    if (in_valid) state_nxt = MUL_I;
            MUL_I:   state_nxt = MUL_Q;
            MUL_Q:   state_nxt = ROOT;
            ROOT:    if (count == CW'(DW-1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            i_reg   <= '0;
            q_reg   <= '0;
            isq     <= '0;
            rad     <= '0;
            rem     <= '0;
            root    <= '0;
            count   <= '0;
            d_out   <= '0;
            d_valid <= 1'b0;
            overrun <= 1'b0;
`ifdef DC_BLOCK_EN
            avg     <= '0;
`endif
        end else begin
            state   <= state_nxt;
            d_valid <= 1'b0;
            if (in_valid && (state != IDLE)) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        i_reg <= I_in;
                        q_reg <= Q_in;
                    end
                end
                MUL_I: isq <= unsigned'(prod);
                MUL_Q: begin
                    rad   <= isq + unsigned'(prod);
                    rem   <= '0;
                    root  <= '0;
                    count <= '0;
                end
                ROOT: begin
                    rad   <= rad << 2;
                    // rem stays below 2^DW before every step, so DW bits suffice.
                    rem   <= DW'(take ? (rem_shift - trial) : rem_shift);
                    root  <= {root[DW-2:0], take};
                    count <= count + 1'b1;
                end
                DONE: begin
                    d_out   <= result;
                    d_valid <= 1'b1;
`ifdef DC_BLOCK_EN
                    avg     <= avg + {{K{1'b0}}, root} - {{K{1'b0}}, avg_int};
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
